// File: rtl/calc2_top_unit.sv
// Four-port tagged 32-bit calculator: per-port capture FSMs feed per-tag slots, one shared ALU.
// Define CALC2_SHIFT_EN to build the shl/shr datapath; otherwise cmds 5/6 answer as invalid.
module calc2_top_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 2
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req1_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [TAG_W-1:0]  req1_tag_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [TAG_W-1:0]  req2_tag_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [TAG_W-1:0]  req3_tag_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [DATA_W-1:0] req4_data_in,
    input  logic [TAG_W-1:0]  req4_tag_in,
    output logic [1:0]        out_resp1,
    output logic [DATA_W-1:0] out_data1,
    output logic [TAG_W-1:0]  out_tag1,
    output logic [1:0]        out_resp2,
    output logic [DATA_W-1:0] out_data2,
    output logic [TAG_W-1:0]  out_tag2,
    output logic [1:0]        out_resp3,
    output logic [DATA_W-1:0] out_data3,
    output logic [TAG_W-1:0]  out_tag3,
    output logic [1:0]        out_resp4,
    output logic [DATA_W-1:0] out_data4,
    output logic [TAG_W-1:0]  out_tag4
);
    localparam int unsigned NPORT = 4;
    localparam int unsigned NSLOT = 1 << TAG_W;

    typedef enum logic {StIdle, StOp2} cap_state_e;

    logic [3:0]        w_cmd_in  [NPORT];
    logic [DATA_W-1:0] w_data_in [NPORT];
    logic [TAG_W-1:0]  w_tag_in  [NPORT];

    cap_state_e        r_state     [NPORT];
    cap_state_e        w_state_nxt [NPORT];
    logic [NPORT-1:0]  w_cap_load;
    logic [NPORT-1:0]  w_slot_set;
    logic [3:0]        r_cap_cmd [NPORT];
    logic [TAG_W-1:0]  r_cap_tag [NPORT];
    logic [DATA_W-1:0] r_cap_op1 [NPORT];

    logic [NSLOT-1:0]  r_pend     [NPORT];
    logic [3:0]        r_slot_cmd [NPORT][NSLOT];
    logic [DATA_W-1:0] r_slot_op1 [NPORT][NSLOT];
    logic [DATA_W-1:0] r_slot_op2 [NPORT][NSLOT];

    logic [1:0]        r_ptr;
    logic [1:0]        w_idx;
    logic [NPORT-1:0]  w_any;
    logic [TAG_W-1:0]  w_low_tag [NPORT];
    logic              w_gnt_vld;
    logic [1:0]        w_gnt_port;
    logic [TAG_W-1:0]  w_gnt_tag;

    logic [3:0]        w_alu_cmd;
    logic [DATA_W-1:0] w_alu_op1;
    logic [DATA_W-1:0] w_alu_op2;
    logic [DATA_W:0]   w_sum;
    logic [1:0]        w_resp;
    logic [DATA_W-1:0] w_res;

    logic [1:0]        r_resp [NPORT];
    logic [DATA_W-1:0] r_data [NPORT];
    logic [TAG_W-1:0]  r_tag  [NPORT];

    assign w_cmd_in  = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
    assign w_data_in = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};
    assign w_tag_in  = '{req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in};

    // Capture FSM next state; a request to a busy tag slot consumes its op2 cycle but is dropped.
    always_comb begin
        w_cap_load = '0;
        w_slot_set = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_state_nxt[p] = r_state[p];
            case (r_state[p])
                StIdle: begin
                    if (w_cmd_in[p] != 4'd0) begin
                        w_cap_load[p]  = 1'b1;
                        w_state_nxt[p] = StOp2;
                    end
                end
                StOp2: begin
                    w_slot_set[p]  = !r_pend[p][r_cap_tag[p]];
                    w_state_nxt[p] = StIdle;
                end
                default: w_state_nxt[p] = StIdle;
            endcase
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NPORT; p++) r_state[p] <= StIdle;
        end else begin
            for (int p = 0; p < NPORT; p++) r_state[p] <= w_state_nxt[p];
        end
    end

    // Round-robin: scanning backwards lets the earliest port after r_ptr win by overwrite.
    always_comb begin
        w_any      = '0;
        w_idx      = '0;
        w_gnt_vld  = 1'b0;
        w_gnt_port = '0;
        for (int p = 0; p < NPORT; p++) begin
            w_any[p]     = |r_pend[p];
            w_low_tag[p] = '0;
            for (int t = NSLOT - 1; t >= 0; t--) begin
                if (r_pend[p][t]) w_low_tag[p] = TAG_W'(t);
            end
        end
        for (int k = NPORT - 1; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_any[w_idx]) begin
                w_gnt_vld  = 1'b1;
                w_gnt_port = w_idx;
            end
        end
        w_gnt_tag = w_low_tag[w_gnt_port];
    end

    always_comb begin
        w_alu_cmd = r_slot_cmd[w_gnt_port][w_gnt_tag];
        w_alu_op1 = r_slot_op1[w_gnt_port][w_gnt_tag];
        w_alu_op2 = r_slot_op2[w_gnt_port][w_gnt_tag];
        w_sum     = {1'b0, w_alu_op1} + {1'b0, w_alu_op2};
        w_resp    = 2'd3;
        w_res     = '0;
        case (w_alu_cmd)
            4'd1: begin
                if (w_sum[DATA_W]) begin
                    w_resp = 2'd2;
                end else begin
                    w_resp = 2'd1;
                    w_res  = w_sum[DATA_W-1:0];
                end
            end
            4'd2: begin
                if (w_alu_op2 > w_alu_op1) begin
                    w_resp = 2'd2;
                end else begin
                    w_resp = 2'd1;
                    w_res  = w_alu_op1 - w_alu_op2;
                end
            end
`ifdef CALC2_SHIFT_EN
            4'd5: begin
                w_resp = 2'd1;
                w_res  = w_alu_op1 << w_alu_op2[4:0];
            end
            4'd6: begin
                w_resp = 2'd1;
                w_res  = w_alu_op1 >> w_alu_op2[4:0];
            end
`endif
            default: ;
        endcase
    end

    // Slot operands need no reset: they are only read while the matching pending bit is set.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (w_slot_set[p]) begin
                r_slot_cmd[p][r_cap_tag[p]] <= r_cap_cmd[p];
                r_slot_op1[p][r_cap_tag[p]] <= r_cap_op1[p];
                r_slot_op2[p][r_cap_tag[p]] <= w_data_in[p];
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NPORT; p++) begin
                r_cap_cmd[p] <= '0;
                r_cap_tag[p] <= '0;
                r_cap_op1[p] <= '0;
                r_pend[p]    <= '0;
                r_resp[p]    <= '0;
                r_data[p]    <= '0;
                r_tag[p]     <= '0;
            end
            r_ptr <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                r_resp[p] <= '0;
                r_data[p] <= '0;
                r_tag[p]  <= '0;
                if (w_cap_load[p]) begin
                    r_cap_cmd[p] <= w_cmd_in[p];
                    r_cap_tag[p] <= w_tag_in[p];
                    r_cap_op1[p] <= w_data_in[p];
                end
                if (w_slot_set[p]) r_pend[p][r_cap_tag[p]] <= 1'b1;
            end
            if (w_gnt_vld) begin
                r_pend[w_gnt_port][w_gnt_tag] <= 1'b0;
                r_resp[w_gnt_port]            <= w_resp;
                r_data[w_gnt_port]            <= w_res;
                r_tag[w_gnt_port]             <= w_gnt_tag;
                r_ptr                         <= w_gnt_port + 2'd1;
            end
        end
    end

    assign out_resp1 = r_resp[0];
    assign out_data1 = r_data[0];
    assign out_tag1  = r_tag[0];
    assign out_resp2 = r_resp[1];
    assign out_data2 = r_data[1];
    assign out_tag2  = r_tag[1];
    assign out_resp3 = r_resp[2];
    assign out_data3 = r_data[2];
    assign out_tag3  = r_tag[2];
    assign out_resp4 = r_resp[3];
    assign out_data4 = r_data[3];
    assign out_tag4  = r_tag[3];
endmodule

// File: tb/tb_calc2_top_unit.sv
// Scoreboard bench for calc2_top_unit: stimulus pushes expected responses, a negedge monitor
// matches each presented response by port and tag, including the cycle it is due.
`timescale 1ns/1ps
module tb_calc2_top_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cmd_d  [4];
    logic [31:0] data_d [4];
    logic [1:0]  tag_d  [4];
    logic [1:0]  resp_o [4];
    logic [31:0] data_o [4];
    logic [1:0]  tag_o  [4];

    calc2_top_unit dut (
        .c_clk       (clk),
        .reset       (rst),
        .req1_cmd_in (cmd_d[0]), .req1_data_in(data_d[0]), .req1_tag_in(tag_d[0]),
        .req2_cmd_in (cmd_d[1]), .req2_data_in(data_d[1]), .req2_tag_in(tag_d[1]),
        .req3_cmd_in (cmd_d[2]), .req3_data_in(data_d[2]), .req3_tag_in(tag_d[2]),
        .req4_cmd_in (cmd_d[3]), .req4_data_in(data_d[3]), .req4_tag_in(tag_d[3]),
        .out_resp1   (resp_o[0]), .out_data1(data_o[0]), .out_tag1(tag_o[0]),
        .out_resp2   (resp_o[1]), .out_data2(data_o[1]), .out_tag2(tag_o[1]),
        .out_resp3   (resp_o[2]), .out_data3(data_o[2]), .out_tag3(tag_o[2]),
        .out_resp4   (resp_o[3]), .out_data4(data_o[3]), .out_tag4(tag_o[3])
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int          port;
        logic [1:0]  tag;
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0]  bt_cmd   [4];
    logic [31:0] bt_a     [4];
    logic [31:0] bt_b     [4];
    logic [1:0]  bt_tag   [4];
    logic [31:0] bt_res   [4];
    int          bt_extra [4];

    task automatic push(input int p, input logic [1:0] tag, input logic [1:0] resp,
                        input logic [31:0] data, input int cyc);
        exp_t e;
        e.port = p; e.tag = tag; e.resp = resp; e.data = data; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Command cycle then op2 cycle; the tag is scrambled in the op2 cycle since it must be ignored.
    task automatic issue_one(input int p, input logic [3:0] cmd, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] tag, input logic [1:0] eresp,
                             input logic [31:0] edata, input int extra, input bit expect_it);
        @(posedge clk); #1;
        cmd_d[p] = cmd; data_d[p] = a; tag_d[p] = tag;
        if (expect_it) push(p, tag, eresp, edata, cyc_cnt + 3 + extra);
        @(posedge clk); #1;
        cmd_d[p] = 4'd0; data_d[p] = b; tag_d[p] = ~tag;
    endtask

    task automatic set_bt(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] tag, input int extra);
        bt_cmd[p] = 4'd1; bt_a[p] = a; bt_b[p] = b; bt_tag[p] = tag;
        bt_res[p] = a + b; bt_extra[p] = extra;
    endtask

    task automatic issue_batch();
        @(posedge clk); #1;
        for (int p = 0; p < 4; p++) begin
            if (bt_cmd[p] != 4'd0) begin
                cmd_d[p] = bt_cmd[p]; data_d[p] = bt_a[p]; tag_d[p] = bt_tag[p];
                push(p, bt_tag[p], 2'd1, bt_res[p], cyc_cnt + 3 + bt_extra[p]);
            end
        end
        @(posedge clk); #1;
        for (int p = 0; p < 4; p++) begin
            if (bt_cmd[p] != 4'd0) begin
                cmd_d[p] = 4'd0; data_d[p] = bt_b[p]; tag_d[p] = ~bt_tag[p];
            end
        end
    endtask

    task automatic do_reset(input bit expect_empty);
        @(posedge clk); #1;
        if (expect_empty) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drained_before_reset: %0d responses outstanding, required 0",
                         sb.size());
            end
        end
        rst = 1'b1;
        sb.delete();
        for (int p = 0; p < 4; p++) begin
            cmd_d[p] = 4'd0; data_d[p] = 32'd0; tag_d[p] = 2'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        int   n_act;
        int   hit;
        exp_t e;
        n_act = 0;
        for (int p = 0; p < 4; p++) begin
            if (resp_o[p] !== 2'd0) begin
                n_act++;
                hit = -1;
                foreach (sb[i]) begin
                    if (hit < 0 && sb[i].port == p && sb[i].tag == tag_o[p]) hit = i;
                end
                checks++;
                if (hit < 0) begin
                    errors++;
                    $display("FAIL unexpected_resp port%0d: resp=%0d tag=%0d data=%h cycle %0d, required none",
                             p + 1, resp_o[p], tag_o[p], data_o[p], cyc_cnt);
                end else begin
                    e = sb[hit];
                    sb.delete(hit);
                    checks++;
                    if (resp_o[p] !== e.resp) begin
                        errors++;
                        $display("FAIL resp port%0d tag%0d: got %0d, required %0d",
                                 p + 1, e.tag, resp_o[p], e.resp);
                    end
                    checks++;
                    if (data_o[p] !== e.data) begin
                        errors++;
                        $display("FAIL data port%0d tag%0d: got %h, required %h",
                                 p + 1, e.tag, data_o[p], e.data);
                    end
                    checks++;
                    if (cyc_cnt != e.cyc) begin
                        errors++;
                        $display("FAIL timing port%0d tag%0d: got cycle %0d, required %0d",
                                 p + 1, e.tag, cyc_cnt, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (data_o[p] !== 32'd0 || tag_o[p] !== 2'd0) begin
                    errors++;
                    $display("FAIL idle_zero port%0d: data=%h tag=%0d, required 0/0",
                             p + 1, data_o[p], tag_o[p]);
                end
            end
        end
        if (n_act > 0) begin
            checks++;
            if (n_act > 1) begin
                errors++;
                $display("FAIL one_resp_per_cycle: got %0d ports responding, required 1", n_act);
            end
        end
    end

    initial begin
        for (int p = 0; p < 4; p++) begin
            cmd_d[p] = 4'd0; data_d[p] = 32'd0; tag_d[p] = 2'd0; bt_cmd[p] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        issue_one(0, 4'd1, 32'h30, 32'h20, 2'd1, 2'd1, 32'h50, 0, 1'b1);
        issue_one(1, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd3, 2'd2, 32'h0, 0, 1'b1);
        issue_one(0, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd2, 2'd1, 32'hFFFF_FFFF, 0, 1'b1);
        issue_one(2, 4'd2, 32'h5, 32'h6, 2'd0, 2'd2, 32'h0, 0, 1'b1);
        issue_one(2, 4'd2, 32'h6, 32'h6, 2'd1, 2'd1, 32'h0, 0, 1'b1);
        issue_one(2, 4'd2, 32'hFFFF_FFFF, 32'h1, 2'd2, 2'd1, 32'hFFFF_FFFE, 0, 1'b1);
`ifdef CALC2_SHIFT_EN
        issue_one(3, 4'd5, 32'h1, 32'h21, 2'd0, 2'd1, 32'h2, 0, 1'b1);
        issue_one(3, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 2'd1, 32'h1, 0, 1'b1);
        issue_one(3, 4'd5, 32'hA5, 32'h20, 2'd2, 2'd1, 32'hA5, 0, 1'b1);
`else
        issue_one(3, 4'd5, 32'h1, 32'h21, 2'd0, 2'd3, 32'h0, 0, 1'b1);
        issue_one(3, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 2'd3, 32'h0, 0, 1'b1);
`endif
        issue_one(1, 4'd9, 32'h1234, 32'h1, 2'd2, 2'd3, 32'h0, 0, 1'b1);
        issue_one(3, 4'd3, 32'h1, 32'h1, 2'd3, 2'd3, 32'h0, 0, 1'b1);
        repeat (4) @(posedge clk);

        // Fresh reset puts the arbiter pointer at port 1: expect ports 1,2,3,4 in order.
        do_reset(1'b1);
        set_bt(0, 32'h1, 32'h2, 2'd0, 0);
        set_bt(1, 32'h3, 32'h4, 2'd1, 1);
        set_bt(2, 32'h5, 32'h6, 2'd2, 2);
        set_bt(3, 32'h7, 32'h8, 2'd3, 3);
        issue_batch();
        repeat (6) @(posedge clk);

        // Port 1 served last so its tag 0 is still pending when the duplicate arrives.
        issue_one(0, 4'd1, 32'h100, 32'h1, 2'd2, 2'd1, 32'h101, 0, 1'b1);
        set_bt(0, 32'h10, 32'h1, 2'd0, 3);
        set_bt(1, 32'h20, 32'h2, 2'd0, 0);
        set_bt(2, 32'h30, 32'h3, 2'd0, 1);
        set_bt(3, 32'h40, 32'h4, 2'd0, 2);
        issue_batch();
        issue_one(0, 4'd1, 32'h99, 32'h1, 2'd0, 2'd1, 32'h9A, 0, 1'b0);
        issue_one(0, 4'd1, 32'h11, 32'h0, 2'd1, 2'd1, 32'h11, 0, 1'b1);
        issue_one(0, 4'd2, 32'h22, 32'h2, 2'd2, 2'd1, 32'h20, 0, 1'b1);
        issue_one(0, 4'd1, 32'h33, 32'h3, 2'd3, 2'd1, 32'h36, 0, 1'b1);
        repeat (6) @(posedge clk);

        // Reset right after op2 of a 4-way batch: nothing may be answered afterwards.
        do_reset(1'b1);
        issue_batch();
        do_reset(1'b0);
        repeat (12) @(posedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            foreach (sb[i])
                $display("FAIL missing_resp port%0d tag%0d: got no response, required resp=%0d data=%h",
                         sb[i].port + 1, sb[i].tag, sb[i].resp, sb[i].data);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
